// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned shift-add multiplier that borrows the shared ALU adder.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   operand handshake; req_a multiplicand, req_b multiplier
//   resp_valid/resp_ready product handshake; resp_hi/resp_lo upper/lower product
//   busy                  high while an operation is in RUN or DONE
//   alu_a/alu_b/alu_oper  ALU operand and opcode drive (combinational)
//   alu_result/alu_cout   ALU sum and carry-out (combinational return)
module alu_mult_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPER_W = 4,
  parameter logic [OPER_W-1:0] ADD_OPER = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_hi,
  output logic [WIDTH-1:0]  resp_lo,
  output logic              busy,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OPER_W-1:0] alu_oper,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand, acc, mplier;
  logic [CNT_W-1:0] cnt;
  logic             zero_op;
  logic [WIDTH-1:0] acc_nxt, mplier_nxt;

  assign zero_op = (req_a == '0) || (req_b == '0);

  // One shift-add step: {cout, sum, mplier} shifted right by one bit.
  assign acc_nxt    = {alu_cout, alu_result[WIDTH-1:1]};
  assign mplier_nxt = {alu_result[0], mplier[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/ALU drive
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_oper   = ADD_OPER;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = zero_op ? DONE : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_b = mplier[0] ? mcand : '0;
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath; response registers capture the product only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      resp_hi <= '0;
      resp_lo <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mcand  <= req_a;
            mplier <= req_b;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) begin
              resp_hi <= '0;
              resp_lo <= '0;
            end
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            resp_hi <= acc_nxt;
            resp_lo <= mplier_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
